level_sensor_conditioner: RTL



---
 rtl/level_pkg.sv | 31 +++
 rtl/probe_debouncer.sv | 50 +++++
 rtl/level_sensor_conditioner.sv | 127 ++++++++++++
 3 files changed

// File: rtl/level_pkg.sv
// Shared level codes and fault-FSM encoding for the tank level path,
// plus the helpers that interpret a low/mid/high probe pattern.
package level_pkg;

    typedef enum logic [1:0] {
        LVL_EMPTY = 2'd0,
        LVL_LOW   = 2'd1,
        LVL_MID   = 2'd2,
        LVL_HIGH  = 2'd3
    } level_e;

    typedef enum logic [1:0] {
        FS_OK      = 2'd0,
        FS_SUSPECT = 2'd1,
        FS_FAULT   = 2'd2
    } fault_state_e;

    // Bit 0 = low, bit 1 = mid, bit 2 = high. Water cannot wet an upper
    // probe without wetting every probe below it.
    function automatic logic pattern_bad(input logic [2:0] f);
        return (f[1] & ~f[0]) | (f[2] & ~f[1]);
    endfunction

    function automatic level_e level_of(input logic [2:0] f);
        if (f[2])      return LVL_HIGH;
        else if (f[1]) return LVL_MID;
        else if (f[0]) return LVL_LOW;
        else           return LVL_EMPTY;
    endfunction

endpackage

// File: rtl/probe_debouncer.sv
// Two-flop synchroniser followed by a debouncer: the stable value flips only
// after DEBOUNCE_CYCLES consecutive disagreeing synchronised samples.
module probe_debouncer #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic stable
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d  = raw;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            // The disagreeing sample that completes the run flips the value.
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable = stable_q;

endmodule

// File: rtl/level_sensor_conditioner.sv
// Conditions the three tank probes into registered low/mid/high flags and
// latches a fault (reported as a full tank) on a persistent impossible pattern.
module level_sensor_conditioner
    import level_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int FAULT_CYCLES    = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       low_raw,
    input  logic       mid_raw,
    input  logic       high_raw,
    input  logic       fault_clear,
    output logic       low,
    output logic       mid,
    output logic       high,
    output logic [1:0] level,
    output logic       valid,
    output logic       fault
);

    localparam int FW = $clog2(FAULT_CYCLES + 1);
    localparam int SW = $clog2(DEBOUNCE_CYCLES + 4);

    logic [2:0]   raw_vec;
    logic [2:0]   deb;
    logic         deb_bad;

    fault_state_e  state_q, state_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic [2:0]    flags_q, flags_d;
    level_e        level_q, level_d;
    logic [SW-1:0] settle_q, settle_d;
    logic          valid_q, valid_d;

    assign raw_vec = {high_raw, mid_raw, low_raw};

    for (genvar gi = 0; gi < 3; gi++) begin : g_probe
        probe_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk    (clk),
            .reset  (reset),
            .raw    (raw_vec[gi]),
            .stable (deb[gi])
        );
    end

    assign deb_bad = pattern_bad(deb);

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        flags_d = flags_q;
        case (state_q)
            FS_OK: begin
                if (deb_bad) begin
                    state_d = FS_SUSPECT;
                    fcnt_d  = FW'(1);
                end else begin
                    flags_d = deb;
                end
            end
            FS_SUSPECT: begin
                // Flags keep the last consistent pattern while we wait it out.
                if (!deb_bad) begin
                    state_d = FS_OK;
                    fcnt_d  = '0;
                end else if (fcnt_q == FW'(FAULT_CYCLES)) begin
                    state_d = FS_FAULT;
                    fcnt_d  = '0;
                    flags_d = 3'b111;
                end else begin
                    fcnt_d = fcnt_q + FW'(1);
                end
            end
            FS_FAULT: begin
                flags_d = 3'b111;
                if (fault_clear && !deb_bad) begin
                    state_d = FS_OK;
                    flags_d = deb;
                end
            end
            default: begin
                state_d = FS_OK;
                fcnt_d  = '0;
            end
        endcase
        level_d = level_of(flags_d);
    end

    always_comb begin
        settle_d = settle_q;
        valid_d  = valid_q;
        if (!valid_q) begin
            settle_d = settle_q + SW'(1);
            valid_d  = (settle_q == SW'(DEBOUNCE_CYCLES + 2));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= FS_OK;
            fcnt_q   <= '0;
            flags_q  <= 3'b000;
            level_q  <= LVL_EMPTY;
            settle_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            fcnt_q   <= fcnt_d;
            flags_q  <= flags_d;
            level_q  <= level_d;
            settle_q <= settle_d;
            valid_q  <= valid_d;
        end
    end

    assign low   = flags_q[0];
    assign mid   = flags_q[1];
    assign high  = flags_q[2];
    assign level = level_q;
    assign valid = valid_q;
    assign fault = (state_q == FS_FAULT);

endmodule
